// File: rtl/pdua_pkg.sv
// Shared PDUA sequencer types: state enumeration and default widths and opcodes.
package pdua_pkg;

    localparam int unsigned          PDUA_OPCODE_W = 5;
    localparam int unsigned          PDUA_USTEP_W  = 3;
    localparam logic [PDUA_OPCODE_W-1:0] PDUA_HALT_OP = 5'h1F;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_HALT,
        ST_INTA
    } state_t;

endpackage

// File: rtl/ir_fetch_seq.sv
// PDUA instruction fetch/execute sequencer: IR/PC/memory strobes plus micro-step counter.
// Optional interrupt acknowledge path enabled by defining IRQ_EN.
module ir_fetch_seq
    import pdua_pkg::*;
#(
    parameter int unsigned          OPCODE_W = PDUA_OPCODE_W,
    parameter int unsigned          USTEP_W  = PDUA_USTEP_W,
    parameter logic [OPCODE_W-1:0]  HALT_OP  = PDUA_HALT_OP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                ustep_last,
    input  logic                stall,
    input  logic                resume,
    input  logic                int_req,
    output logic                ir_ena,
    output logic                ir_sclr,
    output logic                pc_inc,
    output logic                mem_rd,
    output logic [USTEP_W-1:0]  ustep,
    output logic                uop_valid,
    output logic                halted,
    output logic                step_ovf,
    output logic                int_ack
);

    state_t               state, state_nxt;
    logic [USTEP_W-1:0]   ustep_nxt;
    logic                 ovf_nxt;
    logic                 irq;

`ifdef IRQ_EN
    assign irq = int_req;
`else
    logic unused_int_req;
    assign unused_int_req = int_req;
    assign irq = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            ustep    <= '0;
            step_ovf <= 1'b0;
        end else begin
            state    <= state_nxt;
            ustep    <= ustep_nxt;
            step_ovf <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ustep_nxt = ustep;
        ovf_nxt   = step_ovf;
        unique case (state)
            ST_INIT:  state_nxt = ST_FETCH;
            ST_FETCH: if (mem_ready) state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (opcode == HALT_OP) begin
                    state_nxt = ST_HALT;
                end else begin
                    ustep_nxt = '0;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    // Running off the last micro-step ends the instruction as if ustep_last were set.
                    if (ustep_last || (&ustep)) begin
                        if (!ustep_last) ovf_nxt = 1'b1;
                        ustep_nxt = '0;
                        state_nxt = irq ? ST_INTA : ST_FETCH;
                    end else begin
                        ustep_nxt = ustep + USTEP_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (irq)         state_nxt = ST_INTA;
                else if (resume) state_nxt = ST_FETCH;
            end
            ST_INTA:  state_nxt = ST_FETCH;
            default:  state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        ir_ena    = 1'b0;
        ir_sclr   = 1'b0;
        pc_inc    = 1'b0;
        mem_rd    = 1'b0;
        uop_valid = 1'b0;
        halted    = 1'b0;
        int_ack   = 1'b0;
        unique case (state)
            ST_INIT:  ir_sclr = 1'b1;
            ST_FETCH: begin
                mem_rd = 1'b1;
                ir_ena = mem_ready;
                pc_inc = mem_ready;
            end
            ST_EXEC:  uop_valid = 1'b1;
            ST_HALT:  halted = 1'b1;
            ST_INTA: begin
`ifdef IRQ_EN
                int_ack = 1'b1;
                ir_sclr = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ir_fetch_seq.sv
// Directed bench for ir_fetch_seq: behavioural reference checked every cycle plus literal pins.
module tb_ir_fetch_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] opcode = '0;
    logic       mem_ready = 1'b0, ustep_last = 1'b0, stall = 1'b0;
    logic       resume = 1'b0, int_req = 1'b0;
    logic       ir_ena, ir_sclr, pc_inc, mem_rd, uop_valid, halted, step_ovf, int_ack;
    logic [2:0] ustep;

`ifdef IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    int checks = 0;
    int passed = 0;
    bit started = 1'b0;

    ir_fetch_seq dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .ustep_last(ustep_last), .stall(stall), .resume(resume), .int_req(int_req),
        .ir_ena(ir_ena), .ir_sclr(ir_sclr), .pc_inc(pc_inc), .mem_rd(mem_rd),
        .ustep(ustep), .uop_valid(uop_valid), .halted(halted),
        .step_ovf(step_ovf), .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    // Reference: the sequencer's phase held as a readable name, steps as a plain integer.
    string m_phase = "init";
    int    m_step  = 0;
    bit    m_ovf   = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            m_phase = "init"; m_step = 0; m_ovf = 1'b0;
        end else if (m_phase == "init" || m_phase == "inta") begin
            m_phase = "fetch";
        end else if (m_phase == "fetch") begin
            if (mem_ready) m_phase = "decode";
        end else if (m_phase == "decode") begin
            if (opcode == 5'd31) m_phase = "halt";
            else begin m_phase = "exec"; m_step = 0; end
        end else if (m_phase == "exec") begin
            if (!stall) begin
                if (ustep_last || m_step == 7) begin
                    if (!ustep_last) m_ovf = 1'b1;
                    m_step  = 0;
                    m_phase = (IRQ && int_req) ? "inta" : "fetch";
                end else m_step = m_step + 1;
            end
        end else if (m_phase == "halt") begin
            if (IRQ && int_req) m_phase = "inta";
            else if (resume)    m_phase = "fetch";
        end
    end

    function automatic logic [10:0] expected();
        logic acc;
        acc = (m_phase == "fetch") && mem_ready;
        return {acc, (m_phase == "init" || m_phase == "inta"), acc, (m_phase == "fetch"),
                3'(m_step), (m_phase == "exec"), (m_phase == "halt"), m_ovf, (m_phase == "inta")};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (started)
            chk("cycle_outputs",
                {21'b0, ir_ena, ir_sclr, pc_inc, mem_rd, ustep, uop_valid, halted, step_ovf, int_ack},
                {21'b0, expected()});
    end

    task automatic cyc(); @(posedge clk); #1; endtask
    task automatic neg(); @(negedge clk); endtask

    // Called while in FETCH: accept opcode, finish in DECODE.
    task automatic accept(input logic [4:0] op);
        mem_ready = 1'b1; opcode = op;
        cyc();
        mem_ready = 1'b0;
    endtask

    initial begin
        // 1: reset for two cycles, then INIT then FETCH
        cyc(); cyc();
        rst = 1'b0;
        neg(); chk("init_sclr", ir_sclr, 1); chk("init_rd", mem_rd, 0); chk("init_ovf", step_ovf, 0);
        cyc();
        neg(); chk("fetch_rd", mem_rd, 1); chk("fetch_ena_idle", ir_ena, 0); chk("fetch_sclr", ir_sclr, 0);

        // 2: three wait cycles, then accept opcode 02, ustep_last at step 2
        cyc(); cyc(); cyc();
        mem_ready = 1'b1; opcode = 5'h02;
        neg(); chk("accept_ena", ir_ena, 1); chk("accept_pc", pc_inc, 1);
        cyc(); mem_ready = 1'b0;
        neg(); chk("decode_valid", uop_valid, 0); chk("decode_pc", pc_inc, 0);
        cyc(); neg(); chk("exec0_valid", uop_valid, 1); chk("exec0_step", ustep, 0);
        cyc(); cyc(); ustep_last = 1'b1;
        neg(); chk("exec2_step", ustep, 2);
        cyc(); ustep_last = 1'b0;
        neg(); chk("end_fetch", mem_rd, 1); chk("end_valid", uop_valid, 0);

        // 3: stall two cycles at step 1
        accept(5'h03);
        cyc(); cyc(); stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            neg(); chk("stall_step", ustep, 1); chk("stall_valid", uop_valid, 1);
            cyc();
        end
        stall = 1'b0;
        neg(); chk("post_stall_step", ustep, 1);
        cyc(); ustep_last = 1'b1; resume = 1'b1;
        neg(); chk("exec_step2", ustep, 2);
        cyc(); ustep_last = 1'b0; resume = 1'b0;

        // 4: halt opcode, resume back to FETCH
        accept(5'h1F);
        cyc(); neg(); chk("halt_flag", halted, 1); chk("halt_rd", mem_rd, 0);
        cyc(); resume = 1'b1;
        cyc(); resume = 1'b0;
        neg(); chk("resume_fetch", mem_rd, 1); chk("resume_halt", halted, 0);

        // 5: no ustep_last, steps run out after 7
        accept(5'h04);
        for (int i = 0; i < 8; i++) cyc();
        neg(); chk("ovf_pre", step_ovf, 0); chk("ovf_step7", ustep, 7);
        cyc(); neg(); chk("ovf_set", step_ovf, 1); chk("ovf_fetch", mem_rd, 1);
        accept(5'h05);
        cyc(); ustep_last = 1'b1;
        cyc(); ustep_last = 1'b0;
        neg(); chk("ovf_sticky", step_ovf, 1);

        // 6: interrupt at instruction boundary, halt wake, reset mid-EXEC
        accept(5'h06);
        cyc(); int_req = 1'b1;
        cyc(); neg(); chk("irq_mid_ack", int_ack, 0);
        ustep_last = 1'b1;
        cyc(); ustep_last = 1'b0; int_req = 1'b0;
        neg(); chk("irq_ack", int_ack, IRQ); chk("irq_sclr", ir_sclr, IRQ);
        if (IRQ) cyc();
        accept(5'h1F);
        cyc(); int_req = 1'b1;
        cyc(); neg(); chk("halt_irq_ack", int_ack, IRQ); chk("halt_irq_halted", halted, !IRQ);
        int_req = 1'b0; resume = 1'b1;
        cyc(); resume = 1'b0;
        neg(); chk("wake_fetch", mem_rd, 1);
        accept(5'h07);
        cyc(); cyc(); rst = 1'b1;
        cyc(); rst = 1'b0;
        neg(); chk("rst_step", ustep, 0); chk("rst_valid", uop_valid, 0);
        chk("rst_sclr", ir_sclr, 1); chk("rst_ovf", step_ovf, 0);
        cyc(); cyc();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
